// File: rtl/point_sub.sv
// point_sub: sequenced elliptic-curve point subtraction R = P - Q over a 256-bit prime field.
// Define POINT_SUB_DOUBLE_EN to compute 2P for the P = -Q case instead of flagging Error.
package point_sub_pkg;
   typedef struct packed {
      logic [255:0] p;
      logic [255:0] a;
   } curve_parameters_t;

   typedef enum logic [3:0] {
      IDLE, CHECK, INV, MUL_S, MUL_S2, MUL_Y, FINISH
`ifdef POINT_SUB_DOUBLE_EN
      , DBL_SQ, DBL_INV
`endif
   } state_t;
endpackage

module add (
   input  logic [255:0] a,
   input  logic [255:0] b,
   input  logic [255:0] p,
   input  logic         sub,
   output logic [255:0] y
);
   logic [256:0] sum;
   logic [256:0] dif;
   always_comb begin
      sum = {1'b0, a} + {1'b0, b};
      dif = {1'b0, a} - {1'b0, b};
      if (sub) y = dif[256] ? dif[255:0] + p : dif[255:0];
      else     y = (sum >= {1'b0, p}) ? sum[255:0] - p : sum[255:0];
   end
endmodule

// MSB-first interleaved modular multiply: one bit of b per cycle, 256 cycles.
module multiplier (
   input  logic         clk,
   input  logic         Reset,
   input  logic [255:0] a,
   input  logic [255:0] b,
   input  logic [255:0] p,
   output logic         Done,
   output logic [255:0] Product
);
   logic [8:0]   cnt;
   logic [255:0] dbl;
   logic [255:0] acc_next;

   add u_dbl (.a(Product), .b(Product), .p(p), .sub(1'b0), .y(dbl));
   add u_acc (.a(dbl), .b(b[~cnt[7:0]] ? a : '0), .p(p), .sub(1'b0), .y(acc_next));

   assign Done = cnt[8];

   always_ff @(posedge clk) begin
      if (Reset) begin
         cnt     <= '0;
         Product <= '0;
      end else if (!Done) begin
         cnt     <= cnt + 9'd1;
         Product <= acc_next;
      end
   end
endmodule

// Binary extended Euclid; invariants x1*a == u and x2*a == v (mod p), p odd.
module modular_inverse (
   input  logic         clk,
   input  logic         Reset,
   input  logic [255:0] a,
   input  logic [255:0] p,
   output logic         Done,
   output logic [255:0] Inverse
);
   logic [255:0] u, v, x1, x2, sub_y, x1_half, x2_half;
   logic         u_ge_v;

   assign u_ge_v  = u >= v;
   assign x1_half = {1'b0, x1[255:1]} + (x1[0] ? {1'b0, p[255:1]} + 256'd1 : 256'd0);
   assign x2_half = {1'b0, x2[255:1]} + (x2[0] ? {1'b0, p[255:1]} + 256'd1 : 256'd0);
   add u_sub (.a(u_ge_v ? x1 : x2), .b(u_ge_v ? x2 : x1), .p(p), .sub(1'b1), .y(sub_y));

   // u == 0 only for a zero input; terminating there keeps the FSM from hanging
   assign Done    = (u == 256'd1) || (v == 256'd1) || (u == 256'd0);
   assign Inverse = (u == 256'd1) ? x1 : ((v == 256'd1) ? x2 : 256'd0);

   always_ff @(posedge clk) begin
      if (Reset) begin
         u  <= a;
         v  <= p;
         x1 <= 256'd1;
         x2 <= 256'd0;
      end else if (!Done) begin
         if (!u[0]) begin
            u  <= u >> 1;
            x1 <= x1_half;
         end else if (!v[0]) begin
            v  <= v >> 1;
            x2 <= x2_half;
         end else if (u_ge_v) begin
            u  <= u - v;
            x1 <= sub_y;
         end else begin
            v  <= v - u;
            x2 <= sub_y;
         end
      end
   end
endmodule

module point_sub
   import point_sub_pkg::*;
(
   input  logic              clk,
   input  logic              Reset_n,
   input  logic              Start,
   input  logic [255:0]      P_x,
   input  logic [255:0]      P_y,
   input  logic [255:0]      Q_x,
   input  logic [255:0]      Q_y,
   input  curve_parameters_t params,
   output logic              Busy,
   output logic              Done,
   output logic [255:0]      R_x,
   output logic [255:0]      R_y,
   output logic              R_inf,
   output logic              Error,
   output state_t            dbg_state
);
   state_t       state_q, state_d;
   logic [255:0] px_q, py_q, qx_q, qy_q, inv_q, s_q, t_q, u_q;
   logic [255:0] num, den, sum_y, rx_a, rx, pdiff, ry, inv_a;
   logic [255:0] mul_a, mul_b, prod, inv_out;
   logic         mul_reset, inv_reset, mul_done, inv_done, done_q;
   logic         eq_x, eq_y, neg;

   // Subtracting Q is adding Q' = (Qx, -Qy), so the slope numerator is Py + Qy
   add u_sum_y (.a(py_q),  .b(qy_q), .p(params.p), .sub(1'b0), .y(sum_y));
   add u_den   (.a(px_q),  .b(qx_q), .p(params.p), .sub(1'b1), .y(den));
   add u_rx_a  (.a(t_q),   .b(px_q), .p(params.p), .sub(1'b1), .y(rx_a));
   add u_rx    (.a(rx_a),  .b(qx_q), .p(params.p), .sub(1'b1), .y(rx));
   add u_pdiff (.a(px_q),  .b(rx),   .p(params.p), .sub(1'b1), .y(pdiff));
   add u_ry    (.a(u_q),   .b(py_q), .p(params.p), .sub(1'b1), .y(ry));

   assign eq_x = px_q == qx_q;
   assign eq_y = py_q == qy_q;
   assign neg  = eq_x && (sum_y == '0) && (py_q != '0);

`ifdef POINT_SUB_DOUBLE_EN
   logic         dbl_q;
   logic [255:0] x2_q, x2_2, x2_3, num_dbl, py_2;
   add u_x2_2 (.a(x2_q), .b(x2_q),     .p(params.p), .sub(1'b0), .y(x2_2));
   add u_x2_3 (.a(x2_2), .b(x2_q),     .p(params.p), .sub(1'b0), .y(x2_3));
   add u_numd (.a(x2_3), .b(params.a), .p(params.p), .sub(1'b0), .y(num_dbl));
   add u_py_2 (.a(py_q), .b(py_q),     .p(params.p), .sub(1'b0), .y(py_2));
   assign num   = dbl_q ? num_dbl : sum_y;
   assign inv_a = dbl_q ? py_2 : den;
`else
   logic unused_a;
   assign unused_a = ^params.a;
   assign num      = sum_y;
   assign inv_a    = den;
`endif

   multiplier u_mul (
      .clk(clk), .Reset(mul_reset), .a(mul_a), .b(mul_b), .p(params.p),
      .Done(mul_done), .Product(prod)
   );
   modular_inverse u_inv (
      .clk(clk), .Reset(inv_reset), .a(inv_a), .p(params.p),
      .Done(inv_done), .Inverse(inv_out)
   );

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (Start) state_d = CHECK;
         CHECK: begin
            if (eq_x && eq_y) state_d = FINISH;
`ifdef POINT_SUB_DOUBLE_EN
            else if (neg)     state_d = DBL_SQ;
`else
            else if (neg)     state_d = FINISH;
`endif
            else              state_d = INV;
         end
         INV:     if (inv_done) state_d = MUL_S;
         MUL_S:   if (mul_done) state_d = MUL_S2;
         MUL_S2:  if (mul_done) state_d = MUL_Y;
         MUL_Y:   if (mul_done) state_d = FINISH;
         FINISH:  state_d = IDLE;
`ifdef POINT_SUB_DOUBLE_EN
         DBL_SQ:  if (mul_done) state_d = DBL_INV;
         DBL_INV: if (inv_done) state_d = MUL_S;
`endif
         default: state_d = IDLE;
      endcase
   end

   // Reset is reasserted on Done so back-to-back multiplier states restart cleanly
   always_comb begin
      mul_reset = 1'b1;
      inv_reset = 1'b1;
      mul_a     = s_q;
      mul_b     = s_q;
      case (state_q)
         INV:     inv_reset = inv_done;
         MUL_S: begin
            mul_reset = mul_done;
            mul_a     = num;
            mul_b     = inv_q;
         end
         MUL_S2:  mul_reset = mul_done;
         MUL_Y: begin
            mul_reset = mul_done;
            mul_b     = pdiff;
         end
`ifdef POINT_SUB_DOUBLE_EN
         DBL_SQ: begin
            mul_reset = mul_done;
            mul_a     = px_q;
            mul_b     = px_q;
         end
         DBL_INV: inv_reset = inv_done;
`endif
         default: ;
      endcase
      Busy = (state_q != IDLE) || done_q;
   end

   assign Done      = done_q;
   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         px_q <= '0; py_q <= '0; qx_q <= '0; qy_q <= '0;
         inv_q <= '0; s_q <= '0; t_q <= '0; u_q <= '0;
         R_x <= '0; R_y <= '0; R_inf <= 1'b0; Error <= 1'b0; done_q <= 1'b0;
`ifdef POINT_SUB_DOUBLE_EN
         dbl_q <= 1'b0; x2_q <= '0;
`endif
      end else begin
         done_q <= state_q == FINISH;
         case (state_q)
            IDLE: if (Start) begin
               px_q  <= P_x;
               py_q  <= P_y;
               qx_q  <= Q_x;
               qy_q  <= Q_y;
               R_inf <= 1'b0;
               Error <= 1'b0;
`ifdef POINT_SUB_DOUBLE_EN
               dbl_q <= 1'b0;
`endif
            end
            CHECK: begin
               if (eq_x && eq_y) R_inf <= 1'b1;
               else if (neg) begin
`ifdef POINT_SUB_DOUBLE_EN
                  dbl_q <= 1'b1;
                  qx_q  <= px_q;
`else
                  Error <= 1'b1;
`endif
               end
            end
            INV:     if (inv_done) inv_q <= inv_out;
            MUL_S:   if (mul_done) s_q <= prod;
            MUL_S2:  if (mul_done) t_q <= prod;
            MUL_Y:   if (mul_done) u_q <= prod;
            FINISH: begin
               R_x <= (R_inf || Error) ? '0 : rx;
               R_y <= (R_inf || Error) ? '0 : ry;
            end
`ifdef POINT_SUB_DOUBLE_EN
            DBL_SQ:  if (mul_done) x2_q <= prod;
            DBL_INV: if (inv_done) inv_q <= inv_out;
`endif
            default: ;
         endcase
      end
   end
endmodule
